// File: rtl/fwd_hazard_unit.sv
// EX operand forwarding and load-use stall detection driven by an internal destination-tag
// pipeline (EX..WB). Optional statistics counters are built when FWD_HAZ_STATS_EN is defined.
module fwd_hazard_unit #(
  parameter  int RADDR_W      = 5,
  parameter  int NSTG         = 3,
  parameter  int LOAD_FWD_STG = 3,
  localparam int FW           = $clog2(NSTG)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               id_valid,
  input  logic [RADDR_W-1:0] id_rs1_addr,
  input  logic [RADDR_W-1:0] id_rs2_addr,
  input  logic               id_rs1_used,
  input  logic               id_rs2_used,
  input  logic [RADDR_W-1:0] id_rd_addr,
  input  logic               id_reg_write,
  input  logic               id_mem_read,
  input  logic               hold,
  input  logic               flush,
  output logic               stall_id,
  output logic               ex_valid,
  output logic [FW-1:0]      fwd_a_ex,
  output logic [FW-1:0]      fwd_b_ex,
  output logic [15:0]        stat_stall_cnt,
  output logic [15:0]        stat_fwd_cnt
);

  logic               valid_q [1:NSTG];
  logic [RADDR_W-1:0] rd_q    [1:NSTG];
  logic               rw_q    [1:NSTG];
  logic               mr_q    [1:NSTG];
  logic [FW-1:0]      fwd_a_q, fwd_b_q;
  logic [FW-1:0]      fwd_a_d, fwd_b_d;
  logic [NSTG:1]      hit_a, hit_b;
  logic               load_hit;
  logic               load_en;

  genvar gi;
  generate
    for (gi = 1; gi <= NSTG; gi++) begin : g_hit
      assign hit_a[gi] = valid_q[gi] & rw_q[gi] & id_rs1_used & (id_rs1_addr != '0) &
                         (rd_q[gi] == id_rs1_addr);
      assign hit_b[gi] = valid_q[gi] & rw_q[gi] & id_rs2_used & (id_rs2_addr != '0) &
                         (rd_q[gi] == id_rs2_addr);
    end
  endgenerate

  // A load in slot k reaches stage k+1 during the consumer's EX; too early if before LOAD_FWD_STG.
  always_comb begin
    load_hit = 1'b0;
    for (int k = 1; k <= NSTG; k++) begin
      if ((k + 1 < LOAD_FWD_STG) && mr_q[k] && (hit_a[k] || hit_b[k])) load_hit = 1'b1;
    end
  end

  assign stall_id = id_valid & load_hit & ~flush;
  assign load_en  = id_valid & ~stall_id;

  // Descending scan so the youngest producer (smallest k) wins.
  always_comb begin
    fwd_a_d = '0;
    fwd_b_d = '0;
    for (int k = NSTG - 1; k >= 1; k--) begin
      if (hit_a[k]) fwd_a_d = FW'(k);
      if (hit_b[k]) fwd_b_d = FW'(k);
    end
    if (!load_en) begin
      fwd_a_d = '0;
      fwd_b_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 1; k <= NSTG; k++) begin
        valid_q[k] <= 1'b0;
        rd_q[k]    <= '0;
        rw_q[k]    <= 1'b0;
        mr_q[k]    <= 1'b0;
      end
      fwd_a_q <= '0;
      fwd_b_q <= '0;
    end else begin
      if (!hold) begin
        for (int k = 2; k <= NSTG; k++) begin
          valid_q[k] <= valid_q[k-1];
          rd_q[k]    <= rd_q[k-1];
          rw_q[k]    <= rw_q[k-1];
          mr_q[k]    <= mr_q[k-1];
        end
      end
      if (flush) begin
        valid_q[1] <= 1'b0;
        rw_q[1]    <= 1'b0;
        mr_q[1]    <= 1'b0;
        fwd_a_q    <= '0;
        fwd_b_q    <= '0;
      end else if (!hold) begin
        valid_q[1] <= load_en;
        rd_q[1]    <= id_rd_addr;
        rw_q[1]    <= id_reg_write;
        mr_q[1]    <= id_mem_read;
        fwd_a_q    <= fwd_a_d;
        fwd_b_q    <= fwd_b_d;
      end
    end
  end

  assign ex_valid = valid_q[1];
  assign fwd_a_ex = fwd_a_q;
  assign fwd_b_ex = fwd_b_q;

`ifdef FWD_HAZ_STATS_EN
  logic [15:0] stall_cnt_q, fwd_cnt_q;
  logic [16:0] fwd_sum_d;

  assign fwd_sum_d = {1'b0, fwd_cnt_q} + 17'(fwd_a_d != '0) + 17'(fwd_b_d != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      fwd_cnt_q   <= '0;
    end else begin
      if (stall_id && !hold && (stall_cnt_q != 16'hFFFF)) stall_cnt_q <= stall_cnt_q + 16'd1;
      if (!hold && !flush) fwd_cnt_q <= fwd_sum_d[16] ? 16'hFFFF : fwd_sum_d[15:0];
    end
  end

  assign stat_stall_cnt = stall_cnt_q;
  assign stat_fwd_cnt   = fwd_cnt_q;
`else
  assign stat_stall_cnt = '0;
  assign stat_fwd_cnt   = '0;
`endif

endmodule
